// File: rtl/pipe_pkg.sv
// Definitions shared by every pipeline stage register (ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

  // Occupancy state of a two-entry skid stage; the encoding equals the beat count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  function automatic logic [1:0] occ_of(input stage_state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a one-beat skid buffer, flush and stall.
// ready_o never depends on ready_i, so the backpressure path is cut here.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  stage_state_e      state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_p1, skid_ctrl_p0;
  logic [DATA_W-1:0] main_data_p1, skid_data_p0;
  logic              in_fire, out_fire;
  logic              main_ld_in, main_ld_skid, skid_ld;

  assign ready_o  = (state_q != FULL) & ~stall_i;
  assign valid_o  = (state_q != EMPTY);
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i & ~stall_i;
  assign occ_o    = occ_of(state_q);
  assign ctrl_o   = main_ctrl_p1;
  assign data_o   = main_data_p1;

  always_comb begin
    state_d      = state_q;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d    = HALF;
          main_ld_in = 1'b1;
        end
      end
      HALF: begin
        if (in_fire && out_fire) begin
          main_ld_in = 1'b1;
        end else if (in_fire) begin
          state_d = FULL;
          skid_ld = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d      = HALF;
          main_ld_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A flush discards both held beats and whatever is being offered.
    if (flush_i) begin
      state_d      = EMPTY;
      main_ld_in   = 1'b0;
      main_ld_skid = 1'b0;
      skid_ld      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Stage boundary: skid (_p0) feeds main (_p1), main drives the outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_ctrl_p1 <= '0;
      main_data_p1 <= '0;
      skid_ctrl_p0 <= '0;
      skid_data_p0 <= '0;
    end else if (flush_i) begin
      main_ctrl_p1 <= '0;
      skid_ctrl_p0 <= '0;
    end else begin
      if (main_ld_in) begin
        main_ctrl_p1 <= ctrl_i;
        main_data_p1 <= data_i;
      end else if (main_ld_skid) begin
        main_ctrl_p1 <= skid_ctrl_p0;
        main_data_p1 <= skid_data_p0;
      end
      if (skid_ld) begin
        skid_ctrl_p0 <= ctrl_i;
        skid_data_p0 <= data_i;
      end
    end
  end

endmodule
